// File: rtl/mem_ctrl_param.sv
// Parameterised single-port word memory behind a CPU request/ready port.
// A separate configuration port gives direct access while conf_sel is high.
// The CPU port sees a fixed RD_LAT-cycle latency and an out-of-range flag.
module mem_ctrl_param #(
   parameter int unsigned NB     = 4,
   parameter int unsigned AW     = 14,
   parameter int unsigned RD_LAT = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_wren,
   input  logic            mem_rden,
   input  logic [31:0]     mem_addr,
   input  logic [NB-1:0]   mem_wstrb,
   input  logic [8*NB-1:0] mem_wdata,
   output logic [8*NB-1:0] mem_rdata,
   output logic            mem_ready,
   output logic            mem_err,
   input  logic            conf_sel,
   input  logic            conf_wren,
   input  logic            conf_rden,
   input  logic [31:0]     conf_addr,
   input  logic [8*NB-1:0] conf_wdata,
   output logic [8*NB-1:0] conf_rdata,
   output logic            conf_valid
);

   localparam int unsigned DW    = 8 * NB;
   localparam int unsigned LB    = $clog2(NB);
   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned CW    = 2;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_err_pend;
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rd_buf;
   logic [DW-1:0] r_mem_rdata;
   logic [DW-1:0] r_conf_rdata;
   logic          r_mem_ready;
   logic          r_mem_err;
   logic          r_conf_valid;

   logic [AW-1:0] w_idx;
   logic [AW-1:0] w_cidx;
   logic          w_in_range;
   logic          w_accept;
   logic          w_conf_we;
   logic          w_conf_re;
   logic          w_unused_ok;

   assign w_idx      = mem_addr[AW+LB-1:LB];
   assign w_cidx     = conf_addr[AW-1:0];
   assign w_in_range = (mem_addr >> (AW + LB)) == 32'd0;
   assign w_accept   = !reset && (r_state == S_IDLE) && !conf_sel && (mem_wren || mem_rden);
   assign w_conf_we  = !reset && conf_sel && conf_wren;
   assign w_conf_re  = conf_sel && conf_rden;

   // Byte-offset bits and config index bits above AW carry no meaning here.
   assign w_unused_ok = ^{mem_addr[LB-1:0], conf_addr[31:AW]};

   assign mem_rdata  = r_mem_rdata;
   assign mem_ready  = r_mem_ready;
   assign mem_err    = r_mem_err;
   assign conf_rdata = r_conf_rdata;
   assign conf_valid = r_conf_valid;

   // Storage array: read-first sample of the CPU word, strobed CPU writes, full-word config writes.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rd_buf <= w_in_range ? r_mem[w_idx] : '0;
      end
      if (w_accept && mem_wren && w_in_range) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (mem_wstrb[b]) begin
               r_mem[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
      if (w_conf_we) begin
         r_mem[w_cidx] <= conf_wdata;
      end
   end

   // CPU request FSM: accept in IDLE, count down the latency in BUSY, pulse ready at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_err_pend  <= 1'b0;
         r_mem_ready <= 1'b0;
         r_mem_err   <= 1'b0;
         r_mem_rdata <= '0;
      end else begin
         r_mem_ready <= 1'b0;
         r_mem_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state    <= S_BUSY;
                  r_cnt      <= CW'(RD_LAT - 1);
                  r_err_pend <= !w_in_range;
               end
            end
            S_BUSY: begin
               if (r_cnt == '0) begin
                  r_state     <= S_IDLE;
                  r_mem_ready <= 1'b1;
                  r_mem_err   <= r_err_pend;
                  r_mem_rdata <= r_rd_buf;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Config read path: one-cycle registered read, data held between reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_conf_valid <= 1'b0;
         r_conf_rdata <= '0;
      end else begin
         r_conf_valid <= w_conf_re;
         if (w_conf_re) begin
            r_conf_rdata <= r_mem[w_cidx];
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Bench for mem_ctrl_param: four instances with RD_LAT 1..4, each driven by its
// own stimulus process and checked by a scoreboard monitor against a word-array model.
module tb_mem_ctrl_param;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int lane, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL lane%0d %s: got %h expected %h (cycle %0d)", lane, nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input int lane, input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL lane%0d %s: event not as required (cycle %0d)", lane, nm, cyc);
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int unsigned L  = gi + 1;
      localparam int          LN = gi;

      logic        rst_l = 1'b1;
      logic        wren, rden, csel, cwren, crden, ready, err, cvalid;
      logic [31:0] addr, wdata, caddr, cwdata, rdata, crdata;
      logic [3:0]  wstrb;
      bit          fin = 1'b0;

      exp_t        q[$];
      exp_t        cq[$];
      exp_t        me, mc;
      logic [31:0] mdl [16384];
      int unsigned next_free = 0;
      logic [31:0] last_rd = '0;
      logic [31:0] last_crd = '0;
      int unsigned rdy_cnt = 0;

      mem_ctrl_param #(.NB(4), .AW(14), .RD_LAT(L)) u_dut (
         .clk       (clk),
         .reset     (rst_l),
         .mem_wren  (wren),
         .mem_rden  (rden),
         .mem_addr  (addr),
         .mem_wstrb (wstrb),
         .mem_wdata (wdata),
         .mem_rdata (rdata),
         .mem_ready (ready),
         .mem_err   (err),
         .conf_sel  (csel),
         .conf_wren (cwren),
         .conf_rden (crden),
         .conf_addr (caddr),
         .conf_wdata(cwdata),
         .conf_rdata(crdata),
         .conf_valid(cvalid)
      );

      // One clock: drive inputs, let the edge pass, apply the model's view of that edge.
      task automatic cycle(input logic s, input logic c_w, input logic c_r, input logic [31:0] c_a,
                           input logic [31:0] c_d, input logic w, input logic r, input logic [31:0] a,
                           input logic [3:0] st, input logic [31:0] d, output bit acc);
         bit          oor;
         logic [13:0] wi;
         exp_t        e;
         csel = s; cwren = c_w; crden = c_r; caddr = c_a; cwdata = c_d;
         wren = w; rden = r; addr = a; wstrb = st; wdata = d;
         @(posedge clk);
         #1;
         acc = 1'b0;
         if (!rst_l) begin
            if (!s && (w || r) && cyc >= next_free) begin
               acc    = 1'b1;
               oor    = (a[31:16] != 16'h0);
               wi     = a[15:2];
               e.due  = cyc + L;
               e.err  = oor;
               e.data = oor ? 32'h0 : mdl[wi];
               q.push_back(e);
               if (w && !oor) begin
                  for (int b = 0; b < 4; b++) begin
                     if (st[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
                  end
               end
               next_free = cyc + L + 1;
            end
            if (s && c_r) begin
               e.due  = cyc;
               e.err  = 1'b0;
               e.data = mdl[c_a[13:0]];
               cq.push_back(e);
            end
            if (s && c_w) mdl[c_a[13:0]] = c_d;
         end
         @(negedge clk);
      endtask

      task automatic idle(input int n);
         bit a;
         repeat (n) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, a);
      endtask

      task automatic cfg(input logic c_w, input logic c_r, input logic [31:0] c_a, input logic [31:0] c_d,
                         input logic r, input logic [31:0] a);
         bit acc;
         cycle(1'b1, c_w, c_r, c_a, c_d, 1'b0, r, a, 4'hF, 32'h0, acc);
      endtask

      // Hold a CPU request until the model says it has been accepted.
      task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [3:0] st,
                         input logic [31:0] d);
         bit acc;
         acc = 1'b0;
         for (int k = 0; k < int'(L) + 3 && !acc; k++)
            cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, w, r, a, st, d, acc);
         if (!acc) fail_now(LN, "accept_timeout");
      endtask

      task automatic do_reset();
         #2;
         rst_l = 1'b1;
         wren = 1'b0; rden = 1'b0; csel = 1'b0; cwren = 1'b0; crden = 1'b0;
         repeat (3) @(negedge clk);
         #2;
         check(LN, "rst_ready", 32'(ready), 32'h0);
         check(LN, "rst_err", 32'(err), 32'h0);
         check(LN, "rst_cvalid", 32'(cvalid), 32'h0);
         check(LN, "rst_rdata", rdata, 32'h0);
         check(LN, "rst_crdata", crdata, 32'h0);
         next_free = 0;
         rst_l = 1'b0;
      endtask

      // Scoreboard monitor: pop the expected response whenever the DUT presents one.
      always @(negedge clk) begin
         if (rst_l) begin
            q.delete();
            cq.delete();
            last_rd  = '0;
            last_crd = '0;
         end else begin
            if (ready) begin
               rdy_cnt++;
               if (q.size() == 0) fail_now(LN, "unexpected_ready");
               else begin
                  me = q.pop_front();
                  check(LN, "ready_cycle", cyc, me.due);
                  check(LN, "mem_err", 32'(err), 32'(me.err));
                  check(LN, "mem_rdata", rdata, me.data);
                  last_rd = me.data;
               end
            end else begin
               check(LN, "err_without_ready", 32'(err), 32'h0);
               check(LN, "rdata_hold", rdata, last_rd);
               if (q.size() != 0 && q[0].due < cyc) begin
                  fail_now(LN, "missing_ready");
                  void'(q.pop_front());
               end
            end
            if (cvalid) begin
               if (cq.size() == 0) fail_now(LN, "unexpected_conf_valid");
               else begin
                  mc = cq.pop_front();
                  check(LN, "conf_cycle", cyc, mc.due);
                  check(LN, "conf_rdata", crdata, mc.data);
                  last_crd = mc.data;
               end
            end else begin
               check(LN, "conf_rdata_hold", crdata, last_crd);
               if (cq.size() != 0 && cq[0].due < cyc) begin
                  fail_now(LN, "missing_conf_valid");
                  void'(cq.pop_front());
               end
            end
         end
      end

      initial begin
         bit          acc;
         int unsigned base;
         logic [31:0] ra, ca;
         do_reset();
         for (int i = 0; i < 16; i++) cfg(1'b1, 1'b0, 32'(i), $urandom, 1'b0, 32'h0);
         for (int i = 0; i < 16; i += 5) cfg(1'b0, 1'b1, 32'(i), 32'h0, 1'b0, 32'h0);

         req(1'b1, 1'b0, 32'h10, 4'hF, 32'hA5A5_A5A5);
         idle(2);
         req(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);

         req(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
         req(1'b1, 1'b0, 32'h20, 4'h6, 32'h1122_3344);
         req(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);

         req(1'b0, 1'b1, 32'h0001_0000, 4'h0, 32'h0);
         req(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF);
         req(1'b0, 1'b1, 32'h0000_0000, 4'h0, 32'h0);

         idle(L + 1);
         cfg(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF, 1'b1, 32'h14);
         cfg(1'b0, 1'b1, 32'd5, 32'h0, 1'b1, 32'h14);
         cfg(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'h14);
         cfg(1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 32'h14);
         req(1'b0, 1'b1, 32'h14, 4'h0, 32'h0);

         req(1'b1, 1'b1, 32'h0C, 4'hF, 32'h600D_F00D);
         req(1'b0, 1'b1, 32'h0C, 4'h0, 32'h0);

         idle(L + 1);
         cfg(1'b1, 1'b1, 32'd3, 32'hCAFE_0003, 1'b0, 32'h0);
         idle(1);
         cfg(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 32'h0);
         cycle(1'b0, 1'b1, 1'b1, 32'd3, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc);
         cfg(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 32'h0);

         req(1'b1, 1'b0, 32'h1C, 4'hF, 32'h7777_1C1C);
         idle(1);
         do_reset();
         req(1'b0, 1'b1, 32'h1C, 4'h0, 32'h0);

         idle(L + 2);
         base = rdy_cnt;
         repeat (30) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h10, 4'h0, 32'h0, acc);
         idle(L + 2);
         check(LN, "b2b_ready_count", 32'(rdy_cnt - base), 32'((29 / (L + 1)) + 1));

         for (int i = 0; i < 500; i++) begin
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ra[31:16] = 16'($urandom_range(1, 65535));
            ca = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15));
            cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), ca, $urandom,
                  $urandom_range(0, 2) == 0, 1'($urandom), ra, 4'($urandom), $urandom, acc);
         end
         idle(L + 3);
         fin = 1'b1;
      end
   end

   initial begin
      bit all_done;
      all_done = 1'b0;
      for (int k = 0; k < 60000 && !all_done; k++) begin
         @(posedge clk);
         all_done = g_lane[0].fin && g_lane[1].fin && g_lane[2].fin && g_lane[3].fin;
      end
      if (!all_done) fail_now(-1, "global_timeout");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_param.md
MEM_CTRL_PARAM -- requirements
Module: mem_ctrl_param

Interface
REQ-001 Parameter NB, default 4: bytes per word; data width is 8*NB.
REQ-002 Parameter AW, default 14: word-address bits; depth is 2^AW words.
REQ-003 Parameter RD_LAT, default 2, legal 1..4: cycles from request accept to mem_ready.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_wren  in  1  CPU write request.
REQ-007 mem_rden  in  1  CPU read request.
REQ-008 mem_addr  in  32  CPU byte address; word index = mem_addr[AW+log2(NB)-1:log2(NB)].
REQ-009 mem_wstrb  in  NB  CPU byte-lane write enables.
REQ-010 mem_wdata  in  8*NB  CPU write data.
REQ-011 mem_rdata  out  8*NB  CPU read data.
REQ-012 mem_ready  out  1  one-cycle completion pulse.
REQ-013 mem_err  out  1  out-of-range flag, qualified by mem_ready.
REQ-014 conf_sel  in  1  1 = configuration mode; CPU port held off.
REQ-015 conf_wren  in  1  config full-word write.
REQ-016 conf_rden  in  1  config read.
REQ-017 conf_addr  in  32  config word index; bits [AW-1:0] used.
REQ-018 conf_wdata  in  8*NB  config write data.
REQ-019 conf_rdata  out  8*NB  config read data.
REQ-020 conf_valid  out  1  conf_rdata valid pulse.

Function
REQ-021 Storage is an internal 2^AW x 8*NB array with per-byte write enables; contents are not reset.
REQ-022 FSM states are IDLE and BUSY; reset enters IDLE.
REQ-023 IDLE to BUSY on accept, where accept = IDLE & !conf_sel & (mem_wren|mem_rden).
REQ-024 At accept, the address, operation, and in-range flag are latched, and the latency counter is loaded with RD_LAT-1.
REQ-025 An accepted write commits the strobed bytes to the array in the accept cycle.
REQ-026 Read data is sampled in the accept cycle (read-first), so wren & rden together perform a write and return the pre-write word.
REQ-027 In BUSY, the counter decrements each cycle; at 0, mem_ready = 1 for exactly one cycle and the FSM returns to IDLE.
REQ-028 mem_ready is asserted exactly RD_LAT cycles after the accept edge (RD_LAT=1 gives ready on the next cycle).
REQ-029 A new request is accepted no earlier than the cycle after mem_ready.
REQ-030 mem_wren, mem_rden, mem_addr, mem_wdata, and mem_wstrb are ignored in BUSY.
REQ-031 mem_rdata updates only with mem_ready and holds its value until the next mem_ready.
REQ-032 A request with nonzero mem_addr[31:AW+log2(NB)] is out of range: no array write, mem_rdata = 0, mem_err = 1 with mem_ready.
REQ-033 mem_err = 0 on in-range completions and whenever mem_ready = 0.
REQ-034 conf_sel = 1 blocks new accepts, but an in-flight BUSY operation completes normally.
REQ-035 CPU requests held during conf_sel = 1 are accepted in the first IDLE cycle after conf_sel falls.
REQ-036 The config port acts only when conf_sel = 1.
REQ-037 A config write commits the full word in the same cycle.
REQ-038 A config read returns conf_rdata with conf_valid = 1 one cycle later; conf_rdata holds between reads.
REQ-039 conf_wren & conf_rden together perform the write, and the read returns the pre-write word.
REQ-040 Config accesses with conf_sel = 0 are ignored and conf_valid stays 0.

Reset
REQ-041 While reset = 1: FSM = IDLE; mem_ready, mem_err, conf_valid = 0; mem_rdata, conf_rdata = 0; counter = 0.
REQ-042 Reset mid-operation abandons the pending completion (no mem_ready pulse).
REQ-043 A write already committed at accept is retained through reset.
REQ-044 The first accept is possible in the first cycle after reset falls.

Verification
REQ-045 RD_LAT=2: CPU write addr 0x10, wdata 0xA5A5A5A5, strb 0xF; then read 0x10 → mem_ready exactly 2 cycles after each accept; read returns 0xA5A5A5A5 with mem_err = 0.
REQ-046 Strobes: word 0x00000000 at addr 0x20; write strb 0x6 with wdata 0x11223344 → readback 0x00223300.
REQ-047 Out of range (AW=14, NB=4): read at 0x00010000 → mem_ready with mem_err = 1 and mem_rdata = 0; write to the same address leaves word 0 unchanged.
REQ-048 Config mode: conf_sel = 1, write 0xDEADBEEF at index 5 while the CPU holds rden at 0x14 → no mem_ready while conf_sel = 1; config read of index 5 gives 0xDEADBEEF with conf_valid one cycle later; after conf_sel falls, the CPU read completes with 0xDEADBEEF.
REQ-049 Reset mid-BUSY (RD_LAT=4): assert reset 2 cycles after a write accept → no mem_ready pulse; after release, readback shows the written data.
REQ-050 Sweep RD_LAT 1..4 with back-to-back requests held high → one mem_ready per RD_LAT+1 cycles, with no overlapping accepts.
